// File: rtl/button_debounce2_pkg.sv
// Shared constants and types for the two-channel button debouncer.
// Optional edge pulses are enabled with the DEBOUNCE_EDGE_EN macro.
package button_debounce2_pkg;

  localparam int DEB_CNT_WIDTH     = 16;
  localparam int DEB_SYNC_STAGES   = 2;
  localparam int DEB_CNT_WIDTH_SIM = 4;

  typedef enum logic {
    LVL_LOW  = 1'b0,
    LVL_HIGH = 1'b1
  } level_e;

endpackage

// File: rtl/button_debounce2_if.sv
// Raw pin levels in, debounced levels (and optional DEBOUNCE_EDGE_EN pulses) out.
// The master drives the raw pins; the slave is the debouncer.
interface button_debounce2_if;

  logic A_RAW;
  logic B_RAW;
  logic A;
  logic B;
`ifdef DEBOUNCE_EDGE_EN
  logic A_RISE;
  logic A_FALL;
  logic B_RISE;
  logic B_FALL;

  modport master (output A_RAW, B_RAW, input A, B, A_RISE, A_FALL, B_RISE, B_FALL);
  modport slave  (input A_RAW, B_RAW, output A, B, A_RISE, A_FALL, B_RISE, B_FALL);
`else
  modport master (output A_RAW, B_RAW, input A, B);
  modport slave  (input A_RAW, B_RAW, output A, B);
`endif

endinterface

// File: rtl/button_debounce2_debounce_channel.sv
// One debounce channel: input synchroniser, stability counter, registered level.
// DEBOUNCE_EDGE_EN adds a delay flop and one-cycle rise/fall pulses.
module debounce_channel
  import button_debounce2_pkg::*;
#(
  parameter int CNT_WIDTH   = DEB_CNT_WIDTH,
  parameter int SYNC_STAGES = DEB_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_nxt;
  level_e                 state;
  level_e                 state_nxt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      state <= LVL_LOW;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], raw};
      cnt   <= cnt_nxt;
      state <= state_nxt;
    end
  end

  // The count only survives an unbroken run of mismatches; the state flips on the
  // edge that would otherwise overflow it, so the counter never wraps.
  always_comb begin
    cnt_nxt   = '0;
    state_nxt = state;
    if (s != state) begin
      if (cnt != '1) begin
        cnt_nxt = cnt + CNT_WIDTH'(1);
      end else begin
        state_nxt = level_e'(s);
      end
    end
  end

  assign level = (state == LVL_HIGH);

`ifdef DEBOUNCE_EDGE_EN
  logic level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;
`endif

endmodule

// File: rtl/button_debounce2.sv
// Two independent debounce channels conditioning the adder operands A and B.
// Define DEBOUNCE_EDGE_EN to expose the per-channel rise/fall pulses.
module button_debounce2
  import button_debounce2_pkg::*;
#(
  parameter int CNT_WIDTH   = DEB_CNT_WIDTH,
  parameter int SYNC_STAGES = DEB_SYNC_STAGES
) (
  input  logic               CLKIN,
  input  logic               RESETN,
  button_debounce2_if.slave  bus
);

  debounce_channel #(
    .CNT_WIDTH   (CNT_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_chan_a (
    .clk   (CLKIN),
    .rst_n (RESETN),
    .raw   (bus.A_RAW),
    .level (bus.A)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .rise  (bus.A_RISE),
    .fall  (bus.A_FALL)
`endif
  );

  debounce_channel #(
    .CNT_WIDTH   (CNT_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_chan_b (
    .clk   (CLKIN),
    .rst_n (RESETN),
    .raw   (bus.B_RAW),
    .level (bus.B)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .rise  (bus.B_RISE),
    .fall  (bus.B_FALL)
`endif
  );

endmodule

// File: tb/tb_button_debounce2.sv
// Directed and randomized bench for button_debounce2 at the simulation counter width.
// The model flips a level when the last 2^CNT_WIDTH synchronised samples all disagree with it.
module tb_button_debounce2;
  import button_debounce2_pkg::*;

  localparam int CW    = DEB_CNT_WIDTH_SIM;
  localparam int SS    = DEB_SYNC_STAGES;
  localparam int DEPTH = 1 << CW;
  localparam int HMAX  = 8192;

  logic CLKIN  = 1'b0;
  logic RESETN = 1'b0;

  button_debounce2_if bus_if ();

  button_debounce2 #(
    .CNT_WIDTH   (CW),
    .SYNC_STAGES (SS)
  ) dut (
    .CLKIN  (CLKIN),
    .RESETN (RESETN),
    .bus    (bus_if)
  );

  always #5 CLKIN = ~CLKIN;

  int   checks   = 0;
  int   failures = 0;
  int   n_edges  = 0;
  logic raw_hist [2][HMAX];
  logic s_hist   [2][HMAX];
  logic exp_lvl  [2];
  logic exp_rise [2];
  logic exp_fall [2];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n_edges = 0;
    for (int ch = 0; ch < 2; ch++) begin
      exp_lvl[ch]  = 1'b0;
      exp_rise[ch] = 1'b0;
      exp_fall[ch] = 1'b0;
    end
  endtask

  // The synchronised sample used at edge n is the raw level sampled SS edges earlier
  // (zero until the reset-cleared chain has filled).
  task automatic model_edge(input logic ra, input logic rb);
    logic s;
    logic all_differ;
    n_edges++;
    for (int ch = 0; ch < 2; ch++) begin
      raw_hist[ch][n_edges] = (ch == 0) ? ra : rb;
      s = (n_edges > SS) ? raw_hist[ch][n_edges-SS] : 1'b0;
      s_hist[ch][n_edges] = s;
      exp_rise[ch] = 1'b0;
      exp_fall[ch] = 1'b0;
      if (n_edges >= DEPTH) begin
        all_differ = 1'b1;
        for (int k = n_edges - DEPTH + 1; k <= n_edges; k++)
          if (s_hist[ch][k] == exp_lvl[ch]) all_differ = 1'b0;
        if (all_differ) begin
          exp_lvl[ch]  = ~exp_lvl[ch];
          exp_rise[ch] = exp_lvl[ch];
          exp_fall[ch] = ~exp_lvl[ch];
        end
      end
    end
  endtask

  // Called at a falling edge; drives raw levels, checks after the next rising edge,
  // and returns at the following falling edge.
  task automatic apply_stimulus(input logic ra, input logic rb);
    bus_if.A_RAW = ra;
    bus_if.B_RAW = rb;
    @(posedge CLKIN);
    #1;
    model_edge(ra, rb);
    check_output("A", bus_if.A, exp_lvl[0]);
    check_output("B", bus_if.B, exp_lvl[1]);
`ifdef DEBOUNCE_EDGE_EN
    check_output("A_RISE", bus_if.A_RISE, exp_rise[0]);
    check_output("A_FALL", bus_if.A_FALL, exp_fall[0]);
    check_output("B_RISE", bus_if.B_RISE, exp_rise[1]);
    check_output("B_FALL", bus_if.B_FALL, exp_fall[1]);
`endif
    @(negedge CLKIN);
  endtask

  task automatic run_hold(input logic ra, input logic rb, input int cycles,
                          output int a_edge, output int b_edge);
    logic a0;
    logic b0;
    a0 = bus_if.A;
    b0 = bus_if.B;
    a_edge = 0;
    b_edge = 0;
    for (int i = 1; i <= cycles; i++) begin
      apply_stimulus(ra, rb);
      if (a_edge == 0 && bus_if.A !== a0) a_edge = i;
      if (b_edge == 0 && bus_if.B !== b0) b_edge = i;
    end
  endtask

  task automatic do_reset(input logic ra, input logic rb, input int cycles);
    bus_if.A_RAW = ra;
    bus_if.B_RAW = rb;
    RESETN = 1'b0;
    #1;
    check_output("rst_A_async", bus_if.A, 1'b0);
    check_output("rst_B_async", bus_if.B, 1'b0);
    check_output("rst_cnt_a", dut.u_chan_a.cnt, '0);
    check_output("rst_cnt_b", dut.u_chan_b.cnt, '0);
    repeat (cycles) @(posedge CLKIN);
    @(negedge CLKIN);
    check_output("rst_A_held", bus_if.A, 1'b0);
    check_output("rst_B_held", bus_if.B, 1'b0);
`ifdef DEBOUNCE_EDGE_EN
    check_output("rst_pulses", {bus_if.A_RISE, bus_if.A_FALL, bus_if.B_RISE, bus_if.B_FALL}, 4'b0);
`endif
    RESETN = 1'b1;
    model_reset();
  endtask

  initial begin
    int ea;
    int eb;
    int hold_a;
    int hold_b;
    logic ra;
    logic rb;

    bus_if.A_RAW = 1'b1;
    bus_if.B_RAW = 1'b1;
    @(negedge CLKIN);

    do_reset(1'b1, 1'b1, 3);
    run_hold(1'b1, 1'b1, 25, ea, eb);
    check_output("reset_release_A_edge", ea, 18);
    check_output("reset_release_B_edge", eb, 18);

    do_reset(1'b0, 1'b0, 2);
    run_hold(1'b0, 1'b0, 5, ea, eb);
    run_hold(1'b1, 1'b0, 25, ea, eb);
    check_output("press_A_edge", ea, 18);
    check_output("press_B_quiet", eb, 0);

    do_reset(1'b0, 1'b0, 2);
    run_hold(1'b1, 1'b0, 15, ea, eb);
    check_output("glitch_A_hold", ea, 0);
    check_output("glitch_cnt_peak", dut.u_chan_a.cnt, 13);
    run_hold(1'b0, 1'b0, 20, ea, eb);
    check_output("glitch_A_after", ea, 0);
    check_output("glitch_cnt_clear", dut.u_chan_a.cnt, 0);

    run_hold(1'b1, 1'b0, 10, ea, eb);
    check_output("bounce_first_high", ea, 0);
    run_hold(1'b0, 1'b0, 1, ea, eb);
    check_output("bounce_low", ea, 0);
    run_hold(1'b1, 1'b0, 30, ea, eb);
    check_output("bounce_A_edge", ea, 18);

    run_hold(1'b0, 1'b0, 25, ea, eb);
    check_output("release_A_edge", ea, 18);
    check_output("release_A_level", bus_if.A, 1'b0);

    run_hold(1'b0, 1'b1, 20, ea, eb);
    check_output("B_press_edge", eb, 18);
    check_output("B_press_A_quiet", ea, 0);
    run_hold(1'b1, 1'b1, 10, ea, eb);
    check_output("midcount_cnt", dut.u_chan_a.cnt, 8);
    check_output("midcount_B_level", bus_if.B, 1'b1);
    do_reset(1'b1, 1'b1, 2);
    run_hold(1'b1, 1'b1, 25, ea, eb);
    check_output("requalify_A_edge", ea, 18);
    check_output("requalify_B_edge", eb, 18);

    do_reset(1'b0, 1'b0, 2);
    ra = 1'b0;
    rb = 1'b0;
    hold_a = 0;
    hold_b = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_a == 0) begin
        ra = $urandom_range(0, 1);
        hold_a = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 6);
      end
      if (hold_b == 0) begin
        rb = $urandom_range(0, 1);
        hold_b = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 6);
      end
      apply_stimulus(ra, rb);
      hold_a--;
      hold_b--;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
